// File: rtl/watch_pkg.sv
// Shared encodings for the watch edit controller: mode FSM, repeat FSM, and a sizing helper.
package watch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    EDIT = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_DELAY = 2'd1,
    R_RPT   = 2'd2
  } rpt_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Auto-repeat generator for one held button: pulse on press, again after RPT_DELAY,
// then every RPT_PERIOD cycles while held and not blocked.
module btn_repeat
  import watch_pkg::*;
#(
  parameter int unsigned RPT_DELAY  = 50_000_000,
  parameter int unsigned RPT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic block,
  output logic fire_c,
  output logic pulse
);

  localparam int unsigned RW = $clog2(max_u(RPT_DELAY, RPT_PERIOD) + 1);
  localparam logic [RW-1:0] DELAY_LOAD  = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LOAD = RW'(RPT_PERIOD - 1);

  rpt_state_t    state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          prev_q;

  // prev_q resets high so a level held through reset needs a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b1;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= level;
      pulse   <= fire_c;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_c  = 1'b0;
    if (!level || block) begin
      state_d = R_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (!prev_q) begin
            fire_c  = 1'b1;
            state_d = R_DELAY;
            cnt_d   = DELAY_LOAD;
          end
        end
        R_DELAY, R_RPT: begin
          if (cnt_q == '0) begin
            fire_c  = 1'b1;
            state_d = R_RPT;
            cnt_d   = PERIOD_LOAD;
          end else begin
            cnt_d = cnt_q - RW'(1);
          end
        end
        default: begin
          state_d = R_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/watch_edit_ctrl.sv
// Watch setting controller: RUN/EDIT mode, field cursor, inc/dec auto-repeat,
// edit timeout, activity stretch and cursor blink.
module watch_edit_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 4,
  parameter int unsigned STRETCH    = 10_000_000,
  parameter int unsigned RPT_DELAY  = 50_000_000,
  parameter int unsigned RPT_PERIOD = 10_000_000,
  parameter int unsigned TIMEOUT    = 1_000_000_000,
  parameter int unsigned BLINK_HALF = 25_000_000,
  localparam int unsigned CW        = $clog2(NUM_FIELDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_edit_p,
  input  logic          btn_move_p,
  input  logic          btn_back_p,
  input  logic          btn_reset_p,
  input  logic          btn_up,
  input  logic          btn_down,
  output logic          edit_mode,
  output logic [CW-1:0] cursor,
  output logic          inc_pulse,
  output logic          dec_pulse,
  output logic          reset_pulse,
  output logic          edit_activity,
  output logic          blink
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned AW = $clog2(STRETCH + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  localparam logic [CW-1:0] LAST_FIELD   = CW'(NUM_FIELDS - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT);
  localparam logic [AW-1:0] STRETCH_LOAD = AW'(STRETCH);
  localparam logic [BW-1:0] BLINK_LOAD   = BW'(BLINK_HALF - 1);

  mode_t         mode_q, mode_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic          rstp_q, rstp_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          act_q, act_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;

  logic in_edit, rpt_block, up_fire, dn_fire, any_in, nav_event;

  assign in_edit   = (mode_q == EDIT);
  // Repeat engines only run in EDIT, never on the edit-toggle cycle, and not while both keys are held.
  assign rpt_block = !in_edit || btn_edit_p || (btn_up && btn_down);
  assign any_in    = btn_edit_p || btn_move_p || btn_back_p || btn_reset_p || btn_up || btn_down;
  assign nav_event = btn_move_p || btn_back_p || btn_reset_p || up_fire || dn_fire;

  btn_repeat #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_up (
    .clk(clk), .reset(reset), .level(btn_up), .block(rpt_block),
    .fire_c(up_fire), .pulse(inc_pulse)
  );

  btn_repeat #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_dn (
    .clk(clk), .reset(reset), .level(btn_down), .block(rpt_block),
    .fire_c(dn_fire), .pulse(dec_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= RUN;
      cursor_q <= '0;
      rstp_q   <= 1'b0;
      tcnt_q   <= '0;
      acnt_q   <= '0;
      act_q    <= 1'b0;
      bcnt_q   <= '0;
      blink_q  <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      cursor_q <= cursor_d;
      rstp_q   <= rstp_d;
      tcnt_q   <= tcnt_d;
      acnt_q   <= acnt_d;
      act_q    <= act_d;
      bcnt_q   <= bcnt_d;
      blink_q  <= blink_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    cursor_d = cursor_q;
    rstp_d   = 1'b0;
    tcnt_d   = tcnt_q;
    acnt_d   = acnt_q;
    bcnt_d   = bcnt_q;
    blink_d  = blink_q;

    if (btn_edit_p) begin
      if (in_edit) begin
        mode_d  = RUN;
        tcnt_d  = '0;
        bcnt_d  = '0;
        blink_d = 1'b0;
      end else begin
        mode_d   = EDIT;
        cursor_d = '0;
        tcnt_d   = TIMEOUT_LOAD;
        bcnt_d   = BLINK_LOAD;
        blink_d  = 1'b1;
      end
    end else if (in_edit) begin
      if (btn_move_p && !btn_back_p) begin
        cursor_d = (cursor_q == LAST_FIELD) ? '0 : cursor_q + CW'(1);
      end else if (btn_back_p && !btn_move_p) begin
        cursor_d = (cursor_q == '0) ? LAST_FIELD : cursor_q - CW'(1);
      end
      rstp_d = btn_reset_p;

      if (bcnt_q == '0) begin
        blink_d = !blink_q;
        bcnt_d  = BLINK_LOAD;
      end else begin
        bcnt_d = bcnt_q - BW'(1);
      end

      // Idle countdown: leaving EDIT on the cycle it would reach zero.
      if (nav_event) begin
        tcnt_d = TIMEOUT_LOAD;
      end else if (tcnt_q <= TW'(1)) begin
        mode_d  = RUN;
        tcnt_d  = '0;
        bcnt_d  = '0;
        blink_d = 1'b0;
      end else begin
        tcnt_d = tcnt_q - TW'(1);
      end
    end

    if (any_in) begin
      acnt_d = STRETCH_LOAD;
    end else if (acnt_q != '0) begin
      acnt_d = acnt_q - AW'(1);
    end
    act_d = any_in || (acnt_d != '0);
  end

  assign edit_mode     = (mode_q == EDIT);
  assign cursor        = cursor_q;
  assign reset_pulse   = rstp_q;
  assign edit_activity = act_q;
  assign blink         = blink_q;

endmodule

// File: tb/tb_watch_edit_ctrl.sv
// Randomized and directed bench for watch_edit_ctrl against a hold-time based reference model.
module tb_watch_edit_ctrl;

  localparam int NF = 6;
  localparam int ST = 8;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int TO = 100;
  localparam int BH = 7;
  localparam int CW = $clog2(NF);
  localparam int VW = CW + 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_edit_p = 1'b0, btn_move_p = 1'b0, btn_back_p = 1'b0, btn_reset_p = 1'b0;
  logic          btn_up = 1'b0, btn_down = 1'b0;
  logic          edit_mode, inc_pulse, dec_pulse, reset_pulse, edit_activity, blink;
  logic [CW-1:0] cursor;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed as elapsed-time quantities.
  bit m_edit;
  int m_cursor;
  int m_idle;
  int m_bage;
  int m_aage;
  int up_n, dn_n;
  bit seen_low_up, seen_low_dn;
  bit e_inc, e_dec, e_rstp;

  watch_edit_ctrl #(
    .NUM_FIELDS(NF), .STRETCH(ST), .RPT_DELAY(RD), .RPT_PERIOD(RP),
    .TIMEOUT(TO), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_edit_p(btn_edit_p), .btn_move_p(btn_move_p), .btn_back_p(btn_back_p),
    .btn_reset_p(btn_reset_p), .btn_up(btn_up), .btn_down(btn_down),
    .edit_mode(edit_mode), .cursor(cursor), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .reset_pulse(reset_pulse), .edit_activity(edit_activity), .blink(blink)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [VW-1:0] dut_vec();
    return {edit_mode, cursor, inc_pulse, dec_pulse, reset_pulse, edit_activity, blink};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic act_e, blink_e;
    act_e   = (m_aage < ST);
    blink_e = m_edit && (((m_bage / BH) % 2) == 0);
    return {m_edit, CW'(m_cursor), e_inc, e_dec, e_rstp, act_e, blink_e};
  endfunction

  // Pulse on the press cycle, then at RD, RD+RP, RD+2RP ... cycles of continuous hold.
  function automatic bit fires(input int n);
    return (n == 0) || (n >= RD && ((n - RD) % RP) == 0);
  endfunction

  task automatic model_reset();
    m_edit = 0; m_cursor = 0; m_idle = 0; m_bage = 0; m_aage = ST;
    up_n = -1; dn_n = -1; seen_low_up = 0; seen_low_dn = 0;
    e_inc = 0; e_dec = 0; e_rstp = 0;
  endtask

  task automatic model_step();
    bit allow, f_up, f_dn;
    allow = m_edit && !btn_edit_p && !(btn_up && btn_down);
    if (btn_up && allow) begin
      if (up_n >= 0) up_n++;
      else if (seen_low_up) up_n = 0;
    end else up_n = -1;
    if (btn_down && allow) begin
      if (dn_n >= 0) dn_n++;
      else if (seen_low_dn) dn_n = 0;
    end else dn_n = -1;
    f_up = fires(up_n);
    f_dn = fires(dn_n);
    seen_low_up = !btn_up;
    seen_low_dn = !btn_down;
    if (btn_edit_p || btn_move_p || btn_back_p || btn_reset_p || btn_up || btn_down) m_aage = 0;
    else if (m_aage < ST) m_aage++;
    e_inc  = f_up;
    e_dec  = f_dn;
    e_rstp = m_edit && !btn_edit_p && btn_reset_p;
    if (btn_edit_p) begin
      if (m_edit) m_edit = 0;
      else begin m_edit = 1; m_cursor = 0; m_idle = 0; m_bage = 0; end
    end else if (m_edit) begin
      if (btn_move_p && !btn_back_p) m_cursor = (m_cursor + 1) % NF;
      else if (btn_back_p && !btn_move_p) m_cursor = (m_cursor + NF - 1) % NF;
      m_bage++;
      if (btn_move_p || btn_back_p || btn_reset_p || f_up || f_dn) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle >= TO) m_edit = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic press_edit();
    btn_edit_p = 1'b1; tick(); btn_edit_p = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; model_reset(); #1;
    checks++;
    if (dut_vec() !== '0) begin errors++; $display("FAIL reset_state: got %b expected 0", dut_vec()); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== '0) begin errors++; $display("FAIL reset_held: got %b expected 0", dut_vec()); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL post_reset[%0d]: got %b expected %b", i, dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_run_ignore();
    btn_move_p = 1'b1; btn_back_p = 1'b0; btn_reset_p = 1'b1; btn_up = 1'b1;
    tick();
    btn_move_p = 1'b0; btn_reset_p = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) btn_back_p = 1'b1;
      if (i == 11) btn_back_p = 1'b0;
      tick();
      checks++;
      if ({edit_mode, cursor, inc_pulse, dec_pulse, reset_pulse} !== '0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL run_ignore[%0d]: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    btn_up = 1'b0; tick();
  endtask

  task automatic test_cursor_wrap();
    press_edit();
    checks++;
    if (edit_mode !== 1'b1 || cursor !== CW'(0) || blink !== 1'b1) begin
      errors++; $display("FAIL edit_entry: got mode=%b cursor=%0d blink=%b expected 1 0 1", edit_mode, cursor, blink);
    end
    for (int i = 0; i < 7; i++) begin
      btn_move_p = 1'b1; tick(); btn_move_p = 1'b0;
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL move[%0d]: got %b expected %b", i, dut_vec(), exp_vec()); end
    end
    checks++;
    if (cursor !== CW'(1)) begin errors++; $display("FAIL move_wrap: got cursor %0d expected 1", cursor); end
    for (int i = 0; i < 2; i++) begin
      btn_back_p = 1'b1; tick(); btn_back_p = 1'b0;
    end
    checks++;
    if (cursor !== CW'(5)) begin errors++; $display("FAIL back_wrap: got cursor %0d expected 5", cursor); end
    btn_move_p = 1'b1; btn_back_p = 1'b1; btn_reset_p = 1'b1; tick();
    btn_move_p = 1'b0; btn_back_p = 1'b0; btn_reset_p = 1'b0;
    checks++;
    if (cursor !== CW'(5) || reset_pulse !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL move_back_reset: got %b expected %b", dut_vec(), exp_vec());
    end
    tick();
    checks++;
    if (reset_pulse !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_pulse_width: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_autorepeat();
    int want [5] = '{1, 21, 26, 31, 36};
    int got [$];
    btn_up = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 40) btn_up = 1'b0;
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL autorepeat[%0d]: got %b expected %b", k, dut_vec(), exp_vec()); end
      if (inc_pulse === 1'b1) got.push_back(k);
    end
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL autorepeat_count: got %0d pulses expected 5", got.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] != want[i]) begin errors++; $display("FAIL autorepeat_cycle[%0d]: got %0d expected %0d", i, got[i], want[i]); end
      end
    end
  endtask

  task automatic test_conflict();
    btn_up = 1'b1; btn_down = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (inc_pulse !== 1'b0 || dec_pulse !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL conflict[%0d]: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    btn_down = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (inc_pulse !== 1'b0 || dec_pulse !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL conflict_release[%0d]: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    btn_up = 1'b0; tick();
    btn_up = 1'b1; tick();
    checks++;
    if (inc_pulse !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL conflict_repress: got %b expected %b", dut_vec(), exp_vec());
    end
    btn_up = 1'b0; tick();
  endtask

  task automatic test_timeout();
    int fall;
    press_edit();
    checks++;
    if (edit_mode !== 1'b0) begin errors++; $display("FAIL edit_exit: got %b expected 0", edit_mode); end
    press_edit();
    fall = -1;
    for (int k = 1; k <= 150; k++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL timeout[%0d]: got %b expected %b", k, dut_vec(), exp_vec()); end
      if (edit_mode !== 1'b1 && fall < 0) fall = k;
    end
    checks++;
    if (fall != TO) begin errors++; $display("FAIL timeout_cycle: got %0d expected %0d", fall, TO); end
    checks++;
    if (blink !== 1'b0) begin errors++; $display("FAIL timeout_blink: got %b expected 0", blink); end
    btn_move_p = 1'b1; tick(); btn_move_p = 1'b0;
    checks++;
    if (edit_mode !== 1'b0 || cursor !== CW'(0) || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL timeout_move_ignored: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_edit_priority();
    press_edit();
    btn_move_p = 1'b1; tick(); tick(); btn_move_p = 1'b0;
    btn_edit_p = 1'b1; btn_move_p = 1'b1; btn_reset_p = 1'b1; btn_up = 1'b1;
    tick();
    btn_edit_p = 1'b0; btn_move_p = 1'b0; btn_reset_p = 1'b0;
    checks++;
    if (edit_mode !== 1'b0 || cursor !== CW'(2) || inc_pulse !== 1'b0 || reset_pulse !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL edit_priority: got %b expected %b", dut_vec(), exp_vec());
    end
    btn_up = 1'b0; tick();
  endtask

  task automatic test_reset_mid_repeat();
    press_edit();
    btn_up = 1'b1;
    for (int k = 1; k <= 26; k++) tick();
    checks++;
    if (inc_pulse !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL pre_reset_repeat: got %b expected %b", dut_vec(), exp_vec());
    end
    reset = 1'b1; model_reset(); #1;
    checks++;
    if (dut_vec() !== '0) begin errors++; $display("FAIL async_reset: got %b expected 0", dut_vec()); end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    press_edit();
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++;
      if (inc_pulse !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL held_through_reset[%0d]: got %b expected %b", k, dut_vec(), exp_vec());
      end
    end
    btn_up = 1'b0; tick();
    btn_up = 1'b1; tick();
    checks++;
    if (inc_pulse !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL repress_after_reset: got %b expected %b", dut_vec(), exp_vec());
    end
    btn_up = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      btn_edit_p  = ($urandom_range(0, 79) == 0);
      btn_move_p  = ($urandom_range(0, 7) == 0);
      btn_back_p  = ($urandom_range(0, 9) == 0);
      btn_reset_p = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 24) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 29) == 0) btn_down = ~btn_down;
      if ((i % 500) > 380) begin btn_move_p = 1'b0; btn_back_p = 1'b0; btn_reset_p = 1'b0; btn_up = 1'b0; btn_down = 1'b0; end
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL random[%0d]: got %b expected %b", i, dut_vec(), exp_vec()); end
    end
    btn_edit_p = 1'b0; btn_move_p = 1'b0; btn_back_p = 1'b0; btn_reset_p = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_ignore();
    test_cursor_wrap();
    test_autorepeat();
    test_conflict();
    test_timeout();
    test_edit_priority();
    test_reset_mid_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_edit_ctrl.md
WATCH_EDIT_CTRL -- requirements
Module: watch_edit_ctrl

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 4, meaning number of editable fields (2..16), field 0 = most significant.
REQ-002 SHALL have parameter STRETCH, default 10_000_000, meaning edit_activity hold time in clk cycles.
REQ-003 SHALL have parameter RPT_DELAY, default 50_000_000, meaning hold time before auto-repeat starts.
REQ-004 SHALL have parameter RPT_PERIOD, default 10_000_000, meaning cycles between auto-repeat pulses.
REQ-005 SHALL have parameter TIMEOUT, default 1_000_000_000, meaning idle cycles before edit mode auto-exits.
REQ-006 SHALL have parameter BLINK_HALF, default 25_000_000, meaning half-period of the blink output.
REQ-007 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have ports btn_edit_p, btn_move_p, btn_back_p, btn_reset_p  input  1 each  debounced 1-cycle pulses.
REQ-010 SHALL have ports btn_up, btn_down  input  1 each  debounced levels, high while held.
REQ-011 SHALL have port edit_mode  output  1  high while editing.
REQ-012 SHALL have port cursor  output  CW=$clog2(NUM_FIELDS)  selected field.
REQ-013 SHALL have ports inc_pulse, dec_pulse, reset_pulse  output  1 each  registered 1-cycle command pulses.
REQ-014 SHALL have ports edit_activity, blink  output  1 each  activity LED and cursor-blink enable.

Function
REQ-015 SHALL implement mode FSM RUN/EDIT: btn_edit_p toggles RUN<->EDIT; timeout expiry forces RUN.
REQ-016 SHALL ignore btn_move_p, btn_back_p, btn_reset_p, btn_up, btn_down while in RUN, producing no pulses and no cursor change.
REQ-017 SHALL set cursor to 0 on every RUN->EDIT transition.
REQ-018 SHALL, in EDIT, advance cursor on btn_move_p (NUM_FIELDS-1 wraps to 0) and retreat on btn_back_p (0 wraps to NUM_FIELDS-1); both in same cycle leave cursor unchanged.
REQ-019 SHALL, per direction, run repeat FSM R_IDLE/R_DELAY/R_RPT: rising edge of level -> one pulse next cycle, enter R_DELAY; after RPT_DELAY cycles held -> pulse, enter R_RPT; then one pulse every RPT_PERIOD cycles; release -> R_IDLE immediately, no further pulse.
REQ-020 SHALL treat btn_up and btn_down both high as a conflict: no inc/dec pulse, both repeat FSMs to R_IDLE until both released.
REQ-021 SHALL emit reset_pulse one cycle after btn_reset_p in EDIT, cursor unchanged.
REQ-022 SHALL reload the timeout counter to TIMEOUT on any accepted event (edit, move, back, reset, inc or dec pulse) and decrement otherwise in EDIT; reaching 0 forces RUN.
REQ-023 SHALL reload edit_activity counter to STRETCH on any input event in any mode; edit_activity high while counter nonzero or in the reload cycle.
REQ-024 SHALL toggle blink every BLINK_HALF cycles in EDIT starting high on entry; blink=0 in RUN.
REQ-025 SHALL give btn_edit_p priority over all other same-cycle events: the exit cycle issues no pulses and no cursor move.
REQ-026 SHALL size all counters with $clog2(param+1) and never wrap below zero.

Reset
REQ-027 SHALL on reset assert immediately force: edit_mode=0, cursor=0, inc/dec/reset_pulse=0, edit_activity=0, blink=0, all counters 0, repeat FSMs R_IDLE.
REQ-028 SHALL after reset release require a fresh rising edge of btn_up/btn_down before pulsing, even if held across reset.

Structure
REQ-029 SHALL place mode and repeat-state encodings in shared package watch_pkg.
REQ-030 SHALL instantiate sub-module btn_repeat twice (up, down), parameterised by RPT_DELAY and RPT_PERIOD.

Verification
REQ-031 SHALL cover: NUM_FIELDS=6, edit, 7 btn_move_p -> cursor 1; then btn_back_p x2 -> cursor 5.
REQ-032 SHALL cover: RPT_DELAY=20, RPT_PERIOD=5, btn_up held 40 cycles in EDIT -> exactly 5 inc_pulse (cycles 1, 21, 26, 31, 36 after edge).
REQ-033 SHALL cover: btn_up and btn_down high together -> zero inc/dec pulses; release down -> no pulse until up re-pressed.
REQ-034 SHALL cover: TIMEOUT=100, enter EDIT, no input -> edit_mode falls at cycle 100, blink=0, subsequent btn_move_p ignored.
REQ-035 SHALL cover: reset asserted mid auto-repeat with btn_up held -> outputs 0 without clock edge; after release no inc_pulse until btn_up re-pressed.
REQ-036 SHALL cover: btn_edit_p with btn_move_p same cycle in EDIT -> edit_mode=0, cursor unchanged, no pulses.
